// File: rtl/apb_rr_arbiter.sv
// Purpose : round-robin arbiter sharing one APB master port among NREQ requesters.
// Latency : req sampled in IDLE -> SETUP next cycle -> ACCESS after; earliest done 2 cycles after grant edge.
// Backpressure: APB pready stretches ACCESS; requesters hold req until their done strobe.
// Optional: define APB_TIMEOUT_EN to force-complete ACCESS with err after TIMEOUT wait cycles.
module apb_rr_arbiter #(
    parameter int NREQ    = 4,
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   req_write,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [DW-1:0]     rdata,
    output logic              err,
    output logic              psel,
    output logic              penable,
    output logic [AW-1:0]     paddr,
    output logic              pwrite,
    output logic [DW-1:0]     pwdata,
    input  logic [DW-1:0]     prdata,
    input  logic              pready,
    input  logic              pslverr
);

    localparam int LW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t         state;
    logic [LW-1:0]  last;
    logic [LW-1:0]  win_idx;
    logic [LW-1:0]  win;
    logic [LW-1:0]  probe;
    logic           win_vld;
    logic           tmo;

    logic [AW-1:0]  addr_arr  [NREQ];
    logic [DW-1:0]  wdata_arr [NREQ];

    // Reject parameter sets the arbitration and timeout logic cannot support.
    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 2) begin : g_bad_param
        $error("apb_rr_arbiter: NREQ must be 2..8 and TIMEOUT at least 2");
    end

    // Unpack the per-requester address and write-data slices.
    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[g*AW +: AW];
        assign wdata_arr[g] = req_wdata[g*DW +: DW];
    end

    // Round-robin search: first requester after the last one served, wrapping.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        probe   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            probe = LW'((int'(last) + k) % NREQ);
            if (!win_vld && req[probe]) begin
                win     = probe;
                win_vld = 1'b1;
            end
        end
    end

`ifdef APB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] acc_cnt;

    // The final permitted wait cycle ends the transfer with an error.
    assign tmo = penable & ~pready & (acc_cnt == CW'(TIMEOUT - 1));

    // Count ACCESS wait cycles; restarts as each transfer enters ACCESS.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            acc_cnt <= '0;
        end else if (state == SETUP) begin
            acc_cnt <= '0;
        end else if (state == ACCESS && !pready && !tmo) begin
            acc_cnt <= acc_cnt + 1'b1;
        end
    end
`else
    assign tmo = 1'b0;
`endif

    // Completion is visible in the ACCESS cycle that ends the transfer.
    assign done  = gnt & {NREQ{penable & (pready | tmo)}};
    assign err   = penable & ((pready & pslverr) | tmo);
    assign rdata = (pwrite || tmo) ? '0 : prdata;

    // APB sequencing with registered grant, select/enable and address/data.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state   <= IDLE;
            gnt     <= '0;
            psel    <= 1'b0;
            penable <= 1'b0;
            paddr   <= '0;
            pwrite  <= 1'b0;
            pwdata  <= '0;
            last    <= LW'(NREQ - 1);
            win_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        gnt     <= NREQ'(1) << win;
                        win_idx <= win;
                        paddr   <= addr_arr[win];
                        pwrite  <= req_write[win];
                        pwdata  <= wdata_arr[win];
                        psel    <= 1'b1;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (pready || tmo) begin
                        last    <= win_idx;
                        gnt     <= '0;
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    gnt     <= '0;
                    psel    <= 1'b0;
                    penable <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/apb_rr_arbiter.md
Name: apb_rr_arbiter

Overview:
- Shares one APB master port between NREQ local requesters using round-robin arbitration.
- Runs the APB IDLE/SETUP/ACCESS sequence for the winning requester, then returns completion, read data and error to that requester.
- Sits between the local request sources (register/DMA/control logic) and the APB slave fabric.

Parameters:
- NREQ, 4, number of requesters (2..8).
- AW, 8, APB address width.
- DW, 8, APB data width.
- TIMEOUT, 16, ACCESS-cycle limit; used only with APB_TIMEOUT_EN; must be ≥ 2.

Ports:
- pclk  in  1  APB clock; all logic is on the rising edge.
- presetn  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester transfer request; held until that requester's done.
- req_write  in  NREQ  per-requester direction; 1 = write, 0 = read.
- req_addr  in  NREQ*AW  packed addresses; requester i uses [i*AW +: AW].
- req_wdata  in  NREQ*DW  packed write data; requester i uses [i*DW +: DW].
- gnt  out  NREQ  one-hot grant, registered.
- done  out  NREQ  one-hot completion strobe.
- rdata  out  DW  read data, valid while any done bit is 1.
- err  out  1  transfer error, valid while any done bit is 1.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- paddr  out  AW  APB address.
- pwrite  out  1  APB direction.
- pwdata  out  DW  APB write data.
- prdata  in  DW  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB slave error.

Behaviour:
- Reset (asynchronous, presetn = 0):
  - State goes to IDLE.
  - gnt, psel, penable, pwrite, paddr and pwdata go to 0.
  - Round-robin pointer last goes to NREQ-1, so requester 0 has first priority.
  - A reset in SETUP or ACCESS abandons the transfer immediately; no done is issued.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - psel = 0, penable = 0.
  - If req is nonzero, the winner is the first set bit searching last+1, last+2, …, wrapping modulo NREQ.
  - At the clock edge: register gnt = onehot(winner) and latch paddr, pwrite and pwdata from the winner's slices. Then go to SETUP.
  - If req is zero, stay in IDLE.
- SETUP:
  - psel = 1, penable = 0.
  - Always goes to ACCESS on the next edge.
- ACCESS:
  - psel = 1, penable = 1.
  - If pready = 0, stay in ACCESS (wait states, unbounded by default).
  - If pready = 1, the transfer completes:
    - last = winner; gnt clears; next state is IDLE.
- Combinational completion outputs:
  - done[i] = gnt[i] & penable & pready.
  - rdata = prdata when the transfer is a read, else 0.
  - err = pslverr & pready & penable.
- Output stability: paddr, pwrite, pwdata and gnt are registered. They are stable from SETUP through the last ACCESS cycle.
- Latency:
  - req sampled at edge N gives SETUP after edge N, ACCESS after N+1, and earliest done in cycle N+2.
  - There is one mandatory IDLE cycle between transfers, so peak rate is one transfer per 3 cycles.
- req is sampled only in IDLE.
  - Dropping req after grant does not abort; the transfer completes and done still pulses.
  - Requesters drop or refresh req on the edge after done.
- Fairness: the requester just served has lowest priority in the next arbitration. A continuously requesting set is served in cyclic order.
- Single requester: it may be granted back-to-back, with a 3-cycle period.
- Simultaneous events: a new req arriving during SETUP or ACCESS waits for the next IDLE. A req toggling during a transfer has no effect on it.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on SETUP→ACCESS and increments each ACCESS cycle with pready = 0.
  - When the counter reaches TIMEOUT-1 with pready still 0, the transfer is forced complete in that cycle.
  - On a forced completion: done pulses for the winner, err = 1, rdata = 0, and next state is IDLE.
  - A forced completion updates last exactly as a normal completion does.
- Without the macro: no counter is present; ACCESS waits indefinitely for pready, and err depends only on pslverr.

Test Plan:
- Single read: req = 0001, req_write = 0, addr0 = 0x32, prdata = 0xA5, pready = 1. Expect psel for 2 cycles, penable 1 cycle, paddr = 0x32, done = 0001 and rdata = 0xA5 in the ACCESS cycle.
- Contention after reset: req = 1111 held, each requester dropping on its own done. Expect grants in order 0001, 0010, 0100, 1000, with one IDLE cycle between transfers.
- Round-robin rotation: after requester 1 is served, req = 0011. Expect requester 0 granted next, then requester 1.
- Wait states and error: write, wdata = 0x5C, pready low for 3 ACCESS cycles then high with pslverr = 1. Expect pwdata = 0x5C stable for all 4 ACCESS cycles, and done with err = 1 in the last one.
- Reset mid-ACCESS: pull presetn low during a wait state. Expect psel, penable and gnt at 0 immediately, no done, and after release requester 0 has first priority.
- APB_TIMEOUT_EN with TIMEOUT = 16 and pready stuck at 0: expect forced done with err = 1 and rdata = 0 in the 16th ACCESS cycle, then IDLE and the next grant proceeds.
